// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared full-adder slice (two half adders + OR) sequenced LSB first over WIDTH cycles.
// Optional macro SERIAL_ADD_CARRY_EN: when defined, cout is registered from the final carry; otherwise cout is tied to 0.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             ha1_s, ha1_c;
    logic             ha2_s, ha2_c;
    logic             c;
    logic [WIDTH-1:0] s_next;

    // Shared one-bit datapath
    always_comb begin
        ha1_s  = a_sr[0] ^ b_sr[0];
        ha1_c  = a_sr[0] & b_sr[0];
        ha2_s  = ha1_s ^ carry;
        ha2_c  = ha1_s & carry;
        c      = ha1_c | ha2_c;
        s_next = {ha2_s, s_sr[WIDTH-1:1]};
    end

`ifdef SERIAL_ADD_CARRY_EN
    logic cout_q;
    assign cout = cout_q;
`else
    assign cout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
`ifdef SERIAL_ADD_CARRY_EN
            cout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_next;
                    carry <= c;
                    cnt   <= cnt + CNT_W'(1);
                    // Result becomes visible only on the final bit, never partially
                    if (cnt == LAST_CNT) begin
                        sum   <= s_next;
`ifdef SERIAL_ADD_CARRY_EN
                        cout_q <= c;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized operands against an arithmetic reference.
module tb_serial_add_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADD_CARRY_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int vectors;
    int miscompares;

    // Reference model state: result registers as last completed
    logic [W-1:0] m_sum;
    logic         m_cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned t;
        t = longint'(x) + longint'(y);
        return (W + 1)'(t);
    endfunction

    // One full operation; optionally pulses start with all-ones operands at edge pulse_at while busy
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int pulse_at);
        logic [W:0] r;
        r = ref_add(ta, tb);
        @(negedge clk);
        start = 1'b1;
        a = ta;
        b = tb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check("busy_after_accept", busy, 1);
        check("done_after_accept", done, 0);
        for (int k = 1; k <= W; k++) begin
            if (k == pulse_at - 1) begin
                start = 1'b1;
                a = '1;
                b = '1;
            end
            @(posedge clk);
            #1;
            if (k == pulse_at) start = 1'b0;
            check("busy_run", busy, 1);
            if (k < W) begin
                check("done_early", done, 0);
                check("sum_held", sum, m_sum);
                check("cout_held", cout, m_cout);
            end else begin
                m_sum  = r[W-1:0];
                m_cout = CARRY_EN ? r[W] : 1'b0;
                check("done_pulse", done, 1);
                check("sum_result", sum, m_sum);
                check("cout_result", cout, m_cout);
            end
        end
        @(posedge clk);
        #1;
        check("busy_drop", busy, 0);
        check("done_drop", done, 0);
        check("sum_keep", sum, m_sum);
        check("cout_keep", cout, m_cout);
    endtask

    initial begin
        logic [W:0] r2;
        vectors     = 0;
        miscompares = 0;
        m_sum       = '0;
        m_cout      = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        a           = '0;
        b           = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(8'h35, 8'h4A, -1);
        run_op(8'hFF, 8'h01, -1);
        run_op(8'hAA, 8'h56, -1);
        run_op(8'h00, 8'h00, -1);
        run_op(8'hC3, 8'h77, -1);
        run_op(8'h10, 8'h20, 3);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_extra_done", done, 0);
        end

        // Asynchronous reset in the middle of an operation
        run_op(8'hF0, 8'h33, -1);
        @(negedge clk);
        start = 1'b1;
        a = 8'h0F;
        b = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_sum  = '0;
        m_cout = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            check("postrst_done", done, 0);
            check("postrst_busy", busy, 0);
        end

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        @(posedge clk);
        #1;
        a = 8'h80;
        b = 8'h80;
        r2 = ref_add(8'h80, 8'h80);
        for (int i = 1; i <= 2 * W + 3; i++) begin
            @(posedge clk);
            #1;
            if (i == W + 2) start = 1'b0;
            check("b2b_done", done, (i == W || i == 2 * W + 2) ? 1 : 0);
            if (i == W) begin
                check("b2b_sum1", sum, 8'h03);
                check("b2b_cout1", cout, 0);
            end
            if (i == 2 * W + 2) begin
                m_sum  = r2[W-1:0];
                m_cout = CARRY_EN ? r2[W] : 1'b0;
                check("b2b_sum2", sum, 8'h00);
                check("b2b_cout2", cout, CARRY_EN ? 1 : 0);
            end
            if (i == W + 1) check("b2b_gap_busy", busy, 0);
        end
        check("b2b_idle", busy, 0);

        // Randomized operands with random idle gaps
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, W - 1)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences a single shared one-bit adder datapath over WIDTH cycles to add two WIDTH-bit operands. The datapath is two half-adder stages plus an OR gate on the carries. The block accepts a start request, shifts the operands through the datapath LSB first, holds the running carry in a flip-flop, and reports the result with a done pulse. It sits between a requesting sequencer (or testbench) and the gate-level adder cells, trading latency for a single adder instance.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse when sum/cout are updated
- sum  output  WIDTH  result register, held between completions
- cout  output  1  final carry, held with sum

## Operation
- Internal state: a_sr, b_sr, s_sr (WIDTH each), carry (1 bit), cnt (enough bits for 0..WIDTH-1), FSM state.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: a_sr<=a, b_sr<=b, carry<=0, cnt<=0, go RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Datapath computes s=a_sr[0]^b_sr[0]^carry and c=majority(a_sr[0],b_sr[0],carry) through half adder 1 (a_sr[0],b_sr[0]), then half adder 2 (its sum, carry), with the carries ORed.
  - a_sr, b_sr shift right by 1. s_sr shifts right with s entering at MSB. carry<=c. cnt<=cnt+1.
  - When cnt==WIDTH-1, the same edge also loads sum<=final s_sr value (including this bit) and cout<=c, then goes to DONE.
- DONE: done=1 for this single cycle, unconditionally go IDLE.
- start is ignored in RUN and DONE; no queuing. Operand inputs are don't-care outside the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow appears only on cout.
- sum/cout never change except on the final RUN edge or reset; intermediate bits are never visible.

## Timing
- Reset (async assert, any state, including mid-RUN): state=IDLE; busy=0, done=0, sum=0, cout=0; all internal registers 0. The in-flight operation is discarded.
- Reset deassertion is synchronized externally; the first start is sampled on the first edge after rst_n rises.
- Accepting edge E0: busy=1 after E0.
- RUN edges E1..EWIDTH: sum/cout update at EWIDTH.
- done=1 between EWIDTH and EWIDTH+1. busy drops after EWIDTH+1.
- Latency from accepting edge to done high: WIDTH edges. Throughput: one operation per WIDTH+2 cycles minimum. The next start is accepted at EWIDTH+2 if held high.
- start high continuously: back-to-back operations at WIDTH+2 cycle spacing.
- done and busy are both high in the DONE cycle.

## Configuration
- SERIAL_ADD_CARRY_EN defined: cout is registered from the final carry as described.
- SERIAL_ADD_CARRY_EN undefined: cout is tied to 0 and no cout flop is built. The sum is unaffected (still modulo 2^WIDTH).

## Test plan
- Basic add, WIDTH=8: reset, start with a=0x35, b=0x4A -> done after 8 edges, sum=0x7F, cout=0, busy high 9 cycles.
- Overflow: a=0xFF, b=0x01 -> sum=0x00; cout=1 with SERIAL_ADD_CARRY_EN, cout=0 without.
- Carry chain: a=0xAA, b=0x56 -> sum=0x00, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0 (carry cleared per operation).
- Ignore while busy: start a=0x10, b=0x20, then pulse start with a=0xFF, b=0xFF at edge 3 -> single done, sum=0x30. sum/cout are unchanged from their prior values until the final edge.
- Reset mid-operation: assert rst_n=0 asynchronously at edge 4 of a=0x0F, b=0x01 -> busy, done, sum, cout immediately 0. After release, no done appears without a new start.
- Back-to-back: hold start=1 with operand pairs (0x01,0x02), then (0x80,0x80) -> done pulses 10 cycles apart, sums 0x03 then 0x00 with cout=1.
